// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha20 keystream sequencer.
// Covers block geometry, the counter word and the control FSM states.
package chacha_pkg;

  typedef logic [31:0] word_t;

  localparam int BLOCK_BYTES = 64;
  localparam int KS_BLOCK_W  = 8 * BLOCK_BYTES;
  localparam int IDX_W       = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_LOAD,
    S_STREAM,
    S_FIN
  } ks_state_t;

endpackage

// File: rtl/ks_byte_buffer.sv
// Holds one finished 512-bit keystream block and serves it byte by byte.
// The index walks little-endian byte order from 0 up to BLOCK_BYTES-1.
module ks_byte_buffer
  import chacha_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  adv_i,
  input  logic [KS_BLOCK_W-1:0] blk_i,
  output logic [7:0]            byte_o,
  output logic                  last_o
);

  logic [KS_BLOCK_W-1:0] buf_q;
  logic [IDX_W-1:0]      idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
      idx_q <= '0;
    end else if (load_i) begin
      buf_q <= blk_i;
      idx_q <= '0;
    end else if (adv_i) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  assign byte_o = buf_q[{idx_q, 3'b000} +: 8];
  assign last_o = (idx_q == IDX_W'(BLOCK_BYTES - 1));

endmodule

// File: rtl/chacha20_keystream_ctrl.sv
// Sequences ChaCha20 block requests and serialises each block as bytes.
// Owns the 32-bit block counter, the remaining-byte count and wrap detection.
module chacha20_keystream_ctrl
  import chacha_pkg::*;
#(
  parameter int DATA_SIZE   = 8,
  parameter int BLOCK_BYTES = 64,
  parameter int LEN_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [31:0]              init_counter,
  input  logic [LEN_W-1:0]         msg_len,
  output logic                     busy,
  output logic                     done,
  output logic                     ctr_err,
  output logic                     bf_start,
  output logic [31:0]              bf_counter,
  input  logic                     bf_ready,
  input  logic [8*BLOCK_BYTES-1:0] ks_block,
  output logic                     ks_valid,
  input  logic                     ks_ready,
  output logic [DATA_SIZE-1:0]     ks_byte,
  output logic                     ks_last
);

  ks_state_t        state_q, state_d;
  word_t            ctr_q, ctr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             err_q, err_d;
  logic             load, adv;
  logic [7:0]       buf_byte;
  logic             buf_last;

  ks_byte_buffer u_buf (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .adv_i  (adv),
    .blk_i  (ks_block),
    .byte_o (buf_byte),
    .last_o (buf_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ctr_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    rem_d   = rem_q;
    err_d   = err_q;
    load    = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (msg_len != '0) begin
            ctr_d   = init_counter;
            rem_d   = msg_len;
            state_d = S_REQ;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_REQ:  state_d = S_WAIT;
      S_WAIT: if (bf_ready) state_d = S_LOAD;
      S_LOAD: begin
        load    = 1'b1;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (ks_ready) begin
          adv   = 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            state_d = S_FIN;
          end else if (buf_last) begin
            // never let the counter wrap silently
            if (ctr_q == 32'hFFFF_FFFF) begin
              err_d   = 1'b1;
              state_d = S_FIN;
            end else begin
              ctr_d   = ctr_q + 32'd1;
              state_d = S_REQ;
            end
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q == S_REQ) || (state_q == S_WAIT) ||
                      (state_q == S_LOAD) || (state_q == S_STREAM);
  assign done       = (state_q == S_FIN);
  assign ctr_err    = err_q;
  assign bf_start   = (state_q == S_REQ);
  assign bf_counter = ctr_q;
  assign ks_valid   = (state_q == S_STREAM);
  assign ks_last    = ks_valid && (rem_q == LEN_W'(1));
  assign ks_byte    = ks_valid ? DATA_SIZE'(buf_byte) : '0;

endmodule

// File: tb/tb_chacha20_keystream_ctrl.sv
// Randomised bench for chacha20_keystream_ctrl against a ChaCha20 model.
// A block-function stub answers bf_start with real RFC 8439 keystream blocks.
module tb_chacha20_keystream_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  init_counter;
  logic [15:0]  msg_len;
  logic         busy, done, ctr_err, bf_start;
  logic [31:0]  bf_counter;
  logic         bf_ready;
  logic [511:0] ks_block;
  logic         ks_valid;
  logic         ks_ready;
  logic [7:0]   ks_byte;
  logic         ks_last;

  int n_vec = 0;
  int n_bad = 0;

  logic         stub_en  = 1'b1;
  logic         stub_rdy = 1'b0;
  logic         man_rdy  = 1'b0;
  int           cd       = 0;
  logic [31:0]  cap;
  logic [511:0] blk_q    = '0;
  logic [7:0]   obs_bytes[$];

  assign bf_ready = stub_rdy | man_rdy;
  assign ks_block = blk_q;

  chacha20_keystream_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .init_counter (init_counter),
    .msg_len      (msg_len),
    .busy         (busy),
    .done         (done),
    .ctr_err      (ctr_err),
    .bf_start     (bf_start),
    .bf_counter   (bf_counter),
    .bf_ready     (bf_ready),
    .ks_block     (ks_block),
    .ks_valid     (ks_valid),
    .ks_ready     (ks_ready),
    .ks_byte      (ks_byte),
    .ks_last      (ks_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // RFC 8439 2.4.2 key 00..1f, nonce 00..00:4a:00..00
  function automatic logic [511:0] cc_block(input logic [31:0] ctr);
    logic [31:0]  s[16];
    logic [31:0]  x[16];
    logic [31:0]  a, b, c, d;
    logic [511:0] r;
    int qa[8], qb[8], qc[8], qd[8];
    qa = '{0, 1, 2, 3, 0, 1, 2, 3};
    qb = '{4, 5, 6, 7, 5, 6, 7, 4};
    qc = '{8, 9, 10, 11, 10, 11, 8, 9};
    qd = '{12, 13, 14, 15, 15, 12, 13, 14};
    s[0] = 32'h61707865;
    s[1] = 32'h3320646e;
    s[2] = 32'h79622d32;
    s[3] = 32'h6b206574;
    for (int k = 0; k < 8; k++)
      s[4+k] = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
    s[12] = ctr;
    s[13] = 32'h0;
    s[14] = 32'h4a000000;
    s[15] = 32'h0;
    x = s;
    for (int rd = 0; rd < 10; rd++) begin
      for (int q = 0; q < 8; q++) begin
        a = x[qa[q]]; b = x[qb[q]]; c = x[qc[q]]; d = x[qd[q]];
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        x[qa[q]] = a; x[qb[q]] = b; x[qc[q]] = c; x[qd[q]] = d;
      end
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
    return r;
  endfunction

  always @(posedge clk) begin
    stub_rdy <= 1'b0;
    if (rst || !stub_en) begin
      cd <= 0;
    end else if (bf_start) begin
      cd  <= int'($urandom_range(6, 1));
      cap <= bf_counter;
    end else if (cd != 0) begin
      if (cd == 1) begin
        stub_rdy <= 1'b1;
        blk_q    <= cc_block(cap);
      end
      cd <= cd - 1;
    end
  end

  task automatic run_msg(input logic [31:0] init, input int len,
                         input int rdy_pct);
    logic [63:0]  avail;
    logic [511:0] blk;
    logic [7:0]   exp_q[$];
    logic [31:0]  ctr_seen[$];
    logic [31:0]  wctr;
    logic [7:0]   hold_b;
    logic         hold_l;
    int nb, nblk, cnt, cyc;
    bit abort, stalled, waiting, got_done;
    avail = (64'h1_0000_0000 - 64'(init)) * 64;
    abort = 64'(len) > avail;
    nb    = abort ? int'(avail) : len;
    nblk  = (nb + 63) / 64;
    for (int bk = 0; bk < nblk; bk++) begin
      blk = cc_block(init + 32'(bk));
      for (int j = 0; j < 64; j++)
        if (bk * 64 + j < nb) exp_q.push_back(blk[8*j +: 8]);
    end
    obs_bytes.delete();
    @(negedge clk);
    start = 1'b1; init_counter = init; msg_len = 16'(len); ks_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; init_counter = $urandom; msg_len = 16'($urandom);
    chk("lat_bf_start", bf_start, len != 0);
    chk("lat_done", done, len == 0);
    chk("busy_on", busy, len != 0);
    chk("err_clr", ctr_err, 0);
    cnt = 0; cyc = 0;
    stalled = 0; waiting = 0; got_done = 0;
    hold_b = '0; hold_l = 1'b0; wctr = '0;
    while (cyc < 20000) begin
      if (bf_start) begin
        ctr_seen.push_back(bf_counter);
        waiting = 1;
        wctr = bf_counter;
      end else if (waiting) begin
        chk("ctr_hold", bf_counter, wctr);
        if (bf_ready) waiting = 0;
      end
      if (done) begin
        got_done = 1;
        break;
      end
      if (ks_valid) begin
        if (stalled) begin
          chk("stall_byte", ks_byte, hold_b);
          chk("stall_last", ks_last, hold_l);
        end
        ks_ready = ($urandom_range(99) < rdy_pct);
        if (ks_ready) begin
          if (cnt < nb) chk("byte", ks_byte, exp_q[cnt]);
          else chk("overrun", cnt, nb);
          chk("last", ks_last, (cnt == nb - 1) && !abort);
          obs_bytes.push_back(ks_byte);
          cnt++;
          stalled = 0;
        end else begin
          stalled = 1;
          hold_b = ks_byte;
          hold_l = ks_last;
        end
      end else begin
        ks_ready = 1'($urandom_range(1));
      end
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", got_done, 1);
    chk("nbytes", cnt, nb);
    chk("ctr_err", ctr_err, abort);
    chk("busy_at_done", busy, 0);
    chk("nblocks", ctr_seen.size(), nblk);
    foreach (ctr_seen[k])
      if (k < nblk) chk("bf_ctr", ctr_seen[k], init + 32'(k));
    if (nblk > 0) chk("ctr_final", bf_counter, init + 32'(nblk - 1));
    ks_ready = 1'b0;
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("valid_idle", ks_valid, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, ctr_err, 0);
    chk({tag, "_bfs"}, bf_start, 0);
    chk({tag, "_valid"}, ks_valid, 0);
    chk({tag, "_last"}, ks_last, 0);
    chk({tag, "_ctr"}, bf_counter, 0);
    chk({tag, "_byte"}, ks_byte, 0);
  endtask

  task automatic reset_test();
    logic [511:0] blk5;
    int cnt, cyc, nstart;
    blk5 = cc_block(32'd5);
    cnt = 0; cyc = 0; nstart = 0;
    @(negedge clk);
    start = 1'b1; init_counter = 32'd5; msg_len = 16'd64; ks_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 2000 && cnt < 10) begin
      if (cyc == 2) begin
        start = 1'b1; init_counter = 32'd77; msg_len = 16'd3;
      end else begin
        start = 1'b0;
      end
      if (bf_start) nstart++;
      if (ks_valid) begin
        chk("rst_byte", ks_byte, blk5[8*cnt +: 8]);
        cnt++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("rst_reached", cnt, 10);
    chk("rst_one_start", nstart, 1);
    chk("rst_ctr_kept", bf_counter, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ks_ready = 1'b1;
    check_reset_vals("midrst");
    stub_en = 1'b0;
    man_rdy = 1'b1;
    @(negedge clk);
    man_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("late_rdy_valid", ks_valid, 0);
      chk("late_rdy_bfs", bf_start, 0);
      chk("late_rdy_busy", busy, 0);
      @(negedge clk);
    end
    stub_en = 1'b1;
  endtask

  initial begin
    logic [31:0] ri;
    rst = 1'b1; start = 1'b0; init_counter = '0; msg_len = '0; ks_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");

    run_msg(32'd1, 64, 100);
    if (obs_bytes.size() >= 4) begin
      chk("rfc_b0", obs_bytes[0], 8'h22);
      chk("rfc_b1", obs_bytes[1], 8'h4f);
      chk("rfc_b2", obs_bytes[2], 8'h51);
      chk("rfc_b3", obs_bytes[3], 8'hf3);
    end else begin
      chk("rfc_count", obs_bytes.size(), 64);
    end
    run_msg(32'd1, 130, 100);
    run_msg(32'd9, 0, 100);
    run_msg(32'd1, 70, 50);
    run_msg(32'hFFFF_FFFF, 100, 100);
    run_msg(32'd1, 5, 100);
    for (int t = 0; t < 6; t++) begin
      ri = ($urandom_range(3) == 0) ? 32'hFFFF_FFFE : $urandom;
      run_msg(ri, int'($urandom_range(200)), int'($urandom_range(100, 30)));
    end
    reset_test();
    run_msg(32'd2, 20, 70);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
